// File: rtl/address_generator_if.sv
// Control/address bundle between the conv controller (master) and the
// address generator (slave).
//
// Handshake: there is no valid/ready pair. ldAdr, rstX, reMem and weMem are
// single-cycle strobes sampled at the rising clock edge; each asserted cycle
// is one operation. adr and doneAdr are always valid, are combinational from
// the generator's registers, and reflect a strobe only after the edge that
// consumed it.
interface address_generator_if #(
    parameter int ADDR_W = 16
);
    logic [1:0]        sel;
    logic              ldAdr;
    logic              rstX;
    logic              reMem;
    logic              weMem;
    logic [ADDR_W-1:0] adr;
    logic              doneAdr;

    modport master (
        output sel, ldAdr, rstX, reMem, weMem,
        input  adr, doneAdr
    );

    modport slave (
        input  sel, ldAdr, rstX, reMem, weMem,
        output adr, doneAdr
    );
endinterface

// File: rtl/address_generator.sv
// Shared memory address generator for the convolution datapath: walks IFM
// KxK windows in raster order (x), linear filter reads (y) and linear OFM
// writes (z), with a held address for the controller's write cycle.
module address_generator #(
    parameter int ADDR_W = 16,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int X_BASE = 0,
    parameter int Y_BASE = 64,
    parameter int Z_BASE = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    address_generator_if.slave    bus
);
    localparam logic [ADDR_W-1:0] X_BASE_A = ADDR_W'(X_BASE);
    localparam logic [ADDR_W-1:0] Y_BASE_A = ADDR_W'(Y_BASE);
    localparam logic [ADDR_W-1:0] Z_BASE_A = ADDR_W'(Z_BASE);
    localparam logic [ADDR_W-1:0] PITCH    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] WC_LAST  = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] WR_LAST  = ADDR_W'(IMG_H - K);

    // Window origin, in-window counters, linear counters, held address, done.
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [ADDR_W-1:0] wc_q, wc_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [ADDR_W-1:0] y_cnt_q, y_cnt_d;
    logic [ADDR_W-1:0] z_cnt_q, z_cnt_d;
    logic [ADDR_W-1:0] held_adr_q, held_adr_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] adr_c;
    logic              x_read;
    logic              y_read;

    // Address mux: pure function of the registers and the current sel.
    always_comb begin
        adr_c = held_adr_q;
        unique case (bus.sel)
            2'b00:   adr_c = X_BASE_A + (wr_q + r_q) * PITCH + wc_q + c_q;
            2'b01:   adr_c = Y_BASE_A + y_cnt_q;
            2'b10:   adr_c = Z_BASE_A + z_cnt_q;
            default: adr_c = held_adr_q;
        endcase
    end

    assign bus.adr     = adr_c;
    assign bus.doneAdr = done_q;

    // Strobe qualification; a finished walk ignores further x reads.
    assign x_read = bus.reMem && (bus.sel == 2'b00) && !done_q;
    assign y_read = bus.reMem && (bus.sel == 2'b01);

    // Next-state logic, priority ldAdr > rstX > reMem; weMem is independent.
    always_comb begin
        wr_d       = wr_q;
        wc_d       = wc_q;
        r_d        = r_q;
        c_d        = c_q;
        y_cnt_d    = y_cnt_q;
        z_cnt_d    = z_cnt_q;
        held_adr_d = (bus.sel != 2'b11) ? adr_c : held_adr_q;
        done_d     = done_q;

        if (bus.ldAdr) begin
            wr_d       = '0;
            wc_d       = '0;
            r_d        = '0;
            c_d        = '0;
            y_cnt_d    = '0;
            z_cnt_d    = '0;
            held_adr_d = X_BASE_A;
            done_d     = 1'b0;
        end else begin
            if (bus.rstX) begin
                // Re-align to the window origin; the window itself stays put.
                r_d = '0;
                c_d = '0;
            end else if (x_read) begin
                if (c_q == K_LAST) begin
                    c_d = '0;
                    if (r_q == K_LAST) begin
                        // Last element of this window: move to the next one.
                        r_d = '0;
                        if (wc_q < WC_LAST) begin
                            wc_d = wc_q + 1'b1;
                        end else if (wr_q < WR_LAST) begin
                            wc_d = '0;
                            wr_d = wr_q + 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end

            if (y_read) begin
                y_cnt_d = y_cnt_q + 1'b1;
            end

            // The write uses the current address; the counter moves after.
            if (bus.weMem) begin
                z_cnt_d = z_cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous clear to the load state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= '0;
            wc_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            y_cnt_q    <= '0;
            z_cnt_q    <= '0;
            held_adr_q <= X_BASE_A;
            done_q     <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            wc_q       <= wc_d;
            r_q        <= r_d;
            c_q        <= c_d;
            y_cnt_q    <= y_cnt_d;
            z_cnt_q    <= z_cnt_d;
            held_adr_q <= held_adr_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_address_generator.sv
// Directed bench for address_generator with a queue-based scoreboard.
module tb_address_generator;
    localparam int ADDR_W = 16;

    logic clk;
    logic rst;

    address_generator_if #(.ADDR_W(ADDR_W)) bus ();

    address_generator #(
        .ADDR_W(ADDR_W), .IMG_W(8), .IMG_H(8), .K(3),
        .X_BASE(0), .Y_BASE(64), .Z_BASE(128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [ADDR_W:0] exp_q[$];   // {doneAdr, adr}
    string           name_q[$];
    logic            chk_req;
    int              n_cmp;
    int              n_bad;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        chk_req = 1'b0;
    end

    // Monitor: compares on the falling edge whenever a check is requested.
    always @(negedge clk) begin
        if (chk_req) begin
            logic [ADDR_W:0] exp_v;
            logic [ADDR_W:0] act_v;
            string           nm;
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL monitor_underflow: check requested with empty queue");
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {bus.doneAdr, bus.adr};
                if (act_v !== exp_v) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s: got adr=%0d done=%0b, want adr=%0d done=%0b",
                             nm, act_v[ADDR_W-1:0], act_v[ADDR_W],
                             exp_v[ADDR_W-1:0], exp_v[ADDR_W]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] s, input logic re, input logic we,
                         input logic ld, input logic rx);
        bus.sel   = s;
        bus.reMem = re;
        bus.weMem = we;
        bus.ldAdr = ld;
        bus.rstX  = rx;
    endtask

    // One clock edge, then drop all strobes (sel is kept).
    task automatic tick();
        @(posedge clk);
        #1;
        bus.reMem = 1'b0;
        bus.weMem = 1'b0;
        bus.ldAdr = 1'b0;
        bus.rstX  = 1'b0;
    endtask

    // Queue an expectation against the current inputs; checked at the next falling edge.
    task automatic chk(input string nm, input int a, input logic d);
        exp_q.push_back({d, ADDR_W'(a)});
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic load();
        drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic xread(input int n);
        for (int i = 0; i < n; i++) begin
            drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    // First window of an 8-wide image with K=3.
    int t1_adr[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset_state", 0, 1'b0);
        rst = 1'b0;
        tick();

        // T1: load then one full window
        load();
        chk("t1_after_load", 0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("t1_read%0d", i), t1_adr[i], 1'b0);
            xread(1);
        end
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_window1_origin", 1, 1'b0);

        // T2: five more windows end the first window row; origin moves to (1,0)
        xread(45);
        chk("t2_row_wrap", 8, 1'b0);

        // T3: all 36 windows; last window origin is (5,5) -> 5*8+5
        load();
        xread(323);
        chk("t3_before_last", 63, 1'b0);
        xread(1);
        chk("t3_done_rises", 45, 1'b1);
        xread(1);
        chk("t3_done_holds", 45, 1'b1);
        load();
        chk("t3_reload", 0, 1'b0);

        // T4: filter reads, then OFM write via the held address
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("t4_y%0d", i), 64 + i, 1'b0);
            drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_y_after", 68, 1'b0);
        drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_z_setup", 128, 1'b0);
        tick();
        drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_write_cycle", 128, 1'b0);
        tick();
        drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_held_after_write", 128, 1'b0);
        drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_z_next", 129, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_x_untouched", 0, 1'b0);

        // T5: rstX+reMem mid-window in window 1 (origin 1); r=1,c=2 -> 1+8+2
        load();
        xread(9 + 5);
        chk("t5_mid_window", 11, 1'b0);
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_rstx_origin", 1, 1'b0);
        // reMem and weMem together: x steps and z steps
        drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_x_with_write", 2, 1'b0);
        drive(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_z_two_writes", 130, 1'b0);
        drive(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_ld_beats_we", 128, 1'b0);

        // T6: async reset pulse between edges, mid-window with y/z advanced
        xread(4);
        drive(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        chk("t6_async_x", 0, 1'b0);
        drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_async_y", 64, 1'b0);
        drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_async_z", 128, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        xread(1);
        chk("t6_x_restart", 1, 1'b0);

        // ---------------- final report ----------------
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
